// File: rtl/pid_pkg.sv
// -----------------------------------------------------------------------------
// pid_pkg
// Shared types and default constants for the buck-converter PID compensator.
//   - state_t   : compensator FSM states
//   - mac_op_t  : accumulator operation requested from the FSM (hold/load/acc)
//   - mac_sel_t : which coefficient/error pair feeds the single multiplier
//   - DEF_*     : default widths and duty clamp limits
//   - ERR_W     : width of the signed error term (ADC width plus sign)
//   - clamp_code: duty limit expressed in accumulator units (d << frac)
// Optional feature macro used by the block: PID_DERIV_EN.
// -----------------------------------------------------------------------------
package pid_pkg;

   localparam int DEF_ADC_W    = 12;
   localparam int DEF_COEF_W   = 12;
   localparam int DEF_FRAC     = 8;
   localparam int DEF_ACC_W    = 28;
   localparam int DEF_DUTY_W   = 7;
   localparam int DEF_DUTY_MAX = 120;
   localparam int DEF_DUTY_MIN = 0;

   localparam int ERR_W = DEF_ADC_W + 1;

   // Clamp limits in accumulator (Q.FRAC) units for the default build
   localparam int DEF_CLAMP_HI = DEF_DUTY_MAX << DEF_FRAC;
   localparam int DEF_CLAMP_LO = DEF_DUTY_MIN << DEF_FRAC;

   typedef enum logic [2:0] {IDLE, ERR, MA, MB, MC, SAT} state_t;
   typedef enum logic [1:0] {MAC_HOLD, MAC_LOAD, MAC_ACC} mac_op_t;
   typedef enum logic [1:0] {SEL_A, SEL_B, SEL_C} mac_sel_t;

   function automatic longint clamp_code(input int d, input int frac);
      return longint'(d) <<< frac;
   endfunction

endpackage

// File: rtl/pid_mac.sv
// -----------------------------------------------------------------------------
// pid_mac
// Registered signed multiply-accumulate shared by all PID terms.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (clears acc)
//   op               : MAC_HOLD / MAC_LOAD (acc <= load_val) / MAC_ACC (acc += a*b)
//   sel              : SEL_A (k_a*e0), SEL_B (k_b*e1), SEL_C (k_c*e2)
//   e0, e1, e2       : signed error history operands
//   k_a, k_b, k_c    : signed Q.FRAC coefficients
//   load_val         : value loaded into acc (previous control output)
//   acc              : accumulator
// -----------------------------------------------------------------------------
module pid_mac import pid_pkg::*; #(
   parameter int E_W    = ERR_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               op,
   input  logic [1:0]               sel,
   input  logic signed [E_W-1:0]    e0,
   input  logic signed [E_W-1:0]    e1,
   input  logic signed [E_W-1:0]    e2,
   input  logic signed [COEF_W-1:0] k_a,
   input  logic signed [COEF_W-1:0] k_b,
   input  logic signed [COEF_W-1:0] k_c,
   input  logic signed [ACC_W-1:0]  load_val,
   output logic signed [ACC_W-1:0]  acc
);

   localparam int P_W = E_W + COEF_W;

   logic signed [E_W-1:0]    opa;
   logic signed [COEF_W-1:0] opb;
   logic signed [P_W-1:0]    prod;

   always_comb begin
      opa = e0;
      opb = k_a;
      case (sel)
         SEL_B:   begin opa = e1; opb = k_b; end
         SEL_C:   begin opa = e2; opb = k_c; end
         default: ;
      endcase
   end

   assign prod = opa * opb;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else begin
         case (op)
            MAC_LOAD: acc <= load_val;
            // signed cast sign-extends the product into the accumulator
            MAC_ACC:  acc <= acc + ACC_W'(prod);
            default:  ;
         endcase
      end
   end

endmodule

// File: rtl/pid_compensator.sv
// -----------------------------------------------------------------------------
// pid_compensator
// Buck-converter PID compensator: one incremental PID update per rising edge
// of comp_tick, time-multiplexed on a single MAC, saturated duty output.
// Optional feature: `define PID_DERIV_EN adds the k_c*e[n-2] term (MC state,
// e2 history); without it the block is a PI form and k_c is ignored.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   comp_tick       : compensator strobe (rising edge starts an update)
//   adc_data, vref  : unsigned ADC sample and reference code
//   k_a, k_b, k_c   : signed Q.FRAC coefficients for e[n], e[n-1], e[n-2]
//   duty            : duty command, held between updates
//   duty_valid      : one-cycle pulse on each duty update
//   busy            : FSM not IDLE
//   sat             : last update was clamped
//   overrun         : sticky, a tick edge arrived while busy
// -----------------------------------------------------------------------------
module pid_compensator import pid_pkg::*; #(
   parameter int ADC_W    = DEF_ADC_W,
   parameter int COEF_W   = DEF_COEF_W,
   parameter int FRAC     = DEF_FRAC,
   parameter int ACC_W    = DEF_ACC_W,
   parameter int DUTY_W   = DEF_DUTY_W,
   parameter int DUTY_MAX = DEF_DUTY_MAX,
   parameter int DUTY_MIN = DEF_DUTY_MIN
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     comp_tick,
   input  logic [ADC_W-1:0]         adc_data,
   input  logic [ADC_W-1:0]         vref,
   input  logic signed [COEF_W-1:0] k_a,
   input  logic signed [COEF_W-1:0] k_b,
   input  logic signed [COEF_W-1:0] k_c,
   output logic [DUTY_W-1:0]        duty,
   output logic                     duty_valid,
   output logic                     busy,
   output logic                     sat,
   output logic                     overrun
);

   localparam int E_W = ADC_W + 1;
   localparam logic signed [ACC_W-1:0] CLAMP_HI = ACC_W'(clamp_code(DUTY_MAX, FRAC));
   localparam logic signed [ACC_W-1:0] CLAMP_LO = ACC_W'(clamp_code(DUTY_MIN, FRAC));

   state_t   state, nxt;
   mac_op_t  mac_op;
   mac_sel_t mac_sel;

   logic                    tick_q;
   logic                    start;
   logic signed [E_W-1:0]   e0, e1;
   logic signed [E_W-1:0]   e2_op;
   logic signed [COEF_W-1:0] kc_op;
   logic signed [ACC_W-1:0] u_prev;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] clamped;
   logic                    clamp_hit;

   // tick_q resets high so a strobe already asserted at reset release is not
   // mistaken for a fresh edge
   assign start = comp_tick & ~tick_q;
   assign busy  = (state != IDLE);

`ifdef PID_DERIV_EN
   logic signed [E_W-1:0] e2;
   assign e2_op = e2;
   assign kc_op = k_c;
`else
   logic unused_kc;
   assign e2_op     = '0;
   assign kc_op     = '0;
   assign unused_kc = ^k_c;
`endif

   pid_mac #(
      .E_W    (E_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .op       (mac_op),
      .sel      (mac_sel),
      .e0       (e0),
      .e1       (e1),
      .e2       (e2_op),
      .k_a      (k_a),
      .k_b      (k_b),
      .k_c      (kc_op),
      .load_val (u_prev),
      .acc      (acc)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt     = state;
      mac_op  = MAC_HOLD;
      mac_sel = SEL_A;
      case (state)
         IDLE: if (start) nxt = ERR;
         ERR: begin
            // acc starts from the previous (already clamped) output: incremental form
            mac_op = MAC_LOAD;
            nxt    = MA;
         end
         MA: begin
            mac_op  = MAC_ACC;
            mac_sel = SEL_A;
            nxt     = MB;
         end
         MB: begin
            mac_op  = MAC_ACC;
            mac_sel = SEL_B;
`ifdef PID_DERIV_EN
            nxt     = MC;
`else
            nxt     = SAT;
`endif
         end
`ifdef PID_DERIV_EN
         MC: begin
            mac_op  = MAC_ACC;
            mac_sel = SEL_C;
            nxt     = SAT;
         end
`endif
         SAT:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // ---------------- saturation ----------------
   always_comb begin
      clamped   = acc;
      clamp_hit = 1'b0;
      if (acc > CLAMP_HI) begin
         clamped   = CLAMP_HI;
         clamp_hit = 1'b1;
      end else if (acc < CLAMP_LO) begin
         clamped   = CLAMP_LO;
         clamp_hit = 1'b1;
      end
   end

   // ---------------- datapath / outputs ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q     <= 1'b1;
         duty       <= '0;
         duty_valid <= 1'b0;
         sat        <= 1'b0;
         overrun    <= 1'b0;
         u_prev     <= '0;
         e0         <= '0;
         e1         <= '0;
`ifdef PID_DERIV_EN
         e2         <= '0;
`endif
      end else begin
         tick_q     <= comp_tick;
         duty_valid <= 1'b0;
         if (start && state != IDLE)
            overrun <= 1'b1;
         if (state == ERR)
            e0 <= $signed({1'b0, vref}) - $signed({1'b0, adc_data});
         if (state == SAT) begin
            // storing the clamped value (not raw acc) is the anti-windup
            u_prev     <= clamped;
            duty       <= clamped[FRAC +: DUTY_W];
            sat        <= clamp_hit;
            duty_valid <= 1'b1;
            e1         <= e0;
`ifdef PID_DERIV_EN
            e2         <= e1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_pid_compensator.sv
module tb_pid_compensator;

   localparam int ADC_W = 12, COEF_W = 12, FRAC = 8, DUTY_W = 7;
   localparam longint HI = 120 <<< FRAC;
   localparam longint LO = 0;
`ifdef PID_DERIV_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 5;
`endif

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     comp_tick;
   logic [ADC_W-1:0]         adc_data, vref;
   logic signed [COEF_W-1:0] k_a, k_b, k_c;
   logic [DUTY_W-1:0]        duty;
   logic                     duty_valid, busy, sat, overrun;

   pid_compensator dut (
      .clk(clk), .rst(rst), .comp_tick(comp_tick), .adc_data(adc_data), .vref(vref),
      .k_a(k_a), .k_b(k_b), .k_c(k_c), .duty(duty), .duty_valid(duty_valid),
      .busy(busy), .sat(sat), .overrun(overrun)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int duty; bit sat; longint cyc; } exp_t;
   exp_t sb[$];

   int checks = 0, failures = 0, pulse_cnt = 0;

   // reference model state
   longint m_u;
   int     m_e1;
`ifdef PID_DERIV_EN
   int     m_e2;
`endif

   task automatic model_reset();
      m_u  = 0;
      m_e1 = 0;
`ifdef PID_DERIV_EN
      m_e2 = 0;
`endif
      sb.delete();
   endtask

   // compute the expected result of the update this edge starts and queue it
   task automatic push_update();
      exp_t   x;
      longint a;
      int     e0;
      e0 = int'(vref) - int'(adc_data);
      a  = m_u + longint'(k_a) * e0 + longint'(k_b) * m_e1;
`ifdef PID_DERIV_EN
      a    = a + longint'(k_c) * m_e2;
      m_e2 = m_e1;
`endif
      m_e1  = e0;
      x.sat = 1'b1;
      if (a > HI)      a = HI;
      else if (a < LO) a = LO;
      else             x.sat = 1'b0;
      m_u    = a;
      x.duty = int'(a >>> FRAC);
      x.cyc  = cyc + LAT;
      sb.push_back(x);
   endtask

   // raise comp_tick for len cycles, total slot of gap cycles
   task automatic drive_tick(input int len, input int gap);
      comp_tick = 1'b1;
      push_update();
      repeat (len) @(negedge clk);
      comp_tick = 1'b0;
      repeat (gap - len) @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      comp_tick = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   // scoreboard consumer: every duty_valid pulse must match the queue head
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (!rst && duty_valid) begin
            pulse_cnt++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_valid got pulse duty=%0d expected no update", duty);
            end else begin
               x = sb.pop_front();
               if (int'(duty) !== x.duty) begin
                  failures++;
                  $display("FAIL sb_duty got %0d expected %0d", duty, x.duty);
               end
               checks++;
               if (sat !== x.sat) begin
                  failures++;
                  $display("FAIL sb_sat got %0b expected %0b", sat, x.sat);
               end
               checks++;
               if (cyc !== x.cyc) begin
                  failures++;
                  $display("FAIL sb_latency got cycle %0d expected cycle %0d", cyc, x.cyc);
               end
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      comp_tick = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (duty !== '0)        begin failures++; $display("FAIL reset_duty got %0d expected 0", duty); end
      checks++; if (duty_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %0b expected 0", duty_valid); end
      checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got %0b expected 0", busy); end
      checks++; if (sat !== 1'b0)        begin failures++; $display("FAIL reset_sat got %0b expected 0", sat); end
      checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL reset_overrun got %0b expected 0", overrun); end
      rst = 1'b0;
      model_reset();
      repeat (10) @(negedge clk);
      checks++; if (pulse_cnt !== 0) begin failures++; $display("FAIL reset_held_tick got %0d pulses expected 0", pulse_cnt); end
      checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_held_busy got %0b expected 0", busy); end
      comp_tick = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_p_step();
      int want [3];
      want[0] = 48; want[1] = 96; want[2] = 120;
      vref = 12'd2048; adc_data = 12'd2000;
      k_a = 12'sd256; k_b = '0; k_c = '0;
      for (int i = 0; i < 3; i++) begin
         drive_tick(1, 12);
         checks++; if (int'(duty) !== want[i]) begin failures++; $display("FAIL p_step_duty%0d got %0d expected %0d", i, duty, want[i]); end
      end
      checks++; if (sat !== 1'b1)    begin failures++; $display("FAIL p_step_sat got %0b expected 1", sat); end
      checks++; if (sb.size() !== 0) begin failures++; $display("FAIL p_step_timeout got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_negative();
      vref = 12'd1000; adc_data = 12'd1500; k_a = 12'sd256;
      drive_tick(1, 12);
      checks++; if (duty !== 7'd0) begin failures++; $display("FAIL neg_duty got %0d expected 0", duty); end
      checks++; if (sat !== 1'b1)  begin failures++; $display("FAIL neg_sat got %0b expected 1", sat); end
      vref = 12'd1010; adc_data = 12'd1000;
      drive_tick(1, 12);
      checks++; if (duty !== 7'd10) begin failures++; $display("FAIL windup_duty got %0d expected 10", duty); end
      checks++; if (sat !== 1'b0)   begin failures++; $display("FAIL windup_sat got %0b expected 0", sat); end
      checks++; if (sb.size() !== 0) begin failures++; $display("FAIL neg_timeout got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_overrun();
      int p0;
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_pre got %0b expected 0", overrun); end
      vref = 12'd1020; adc_data = 12'd1000; k_a = 12'sd256;
      p0 = pulse_cnt;
      comp_tick = 1'b1;
      push_update();
      @(negedge clk); comp_tick = 1'b0;
      repeat (2) @(negedge clk);
      comp_tick = 1'b1;            // second edge 3 clocks after the first
      repeat (2) @(negedge clk);
      comp_tick = 1'b0;
      repeat (12) @(negedge clk);
      checks++; if (overrun !== 1'b1)       begin failures++; $display("FAIL overrun_flag got %0b expected 1", overrun); end
      checks++; if (pulse_cnt - p0 !== 1)   begin failures++; $display("FAIL overrun_pulses got %0d expected 1", pulse_cnt - p0); end
      checks++; if (duty !== 7'd30)         begin failures++; $display("FAIL overrun_duty got %0d expected 30", duty); end
      checks++; if (sb.size() !== 0)        begin failures++; $display("FAIL overrun_timeout got %0d pending expected 0", sb.size()); end
      repeat (20) @(negedge clk);
      checks++; if (overrun !== 1'b1)       begin failures++; $display("FAIL overrun_sticky got %0b expected 1", overrun); end
   endtask

   task automatic test_deriv();
      int want [3];
`ifdef PID_DERIV_EN
      want[0] = 0; want[1] = 0; want[2] = 5;
`else
      want[0] = 0; want[1] = 0; want[2] = 0;
`endif
      k_a = '0; k_b = '0; k_c = 12'sd256;
      for (int i = 0; i < 3; i++) begin
         vref     = (i == 0) ? 12'd1005 : 12'd1000;
         adc_data = 12'd1000;
         drive_tick(1, 12);
         checks++; if (int'(duty) !== want[i]) begin failures++; $display("FAIL deriv_duty%0d got %0d expected %0d", i, duty, want[i]); end
      end
      checks++; if (sb.size() !== 0) begin failures++; $display("FAIL deriv_timeout got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_back_to_back();
      int p0;
      p0 = pulse_cnt;
      vref = 12'd2048;
      k_a = 12'sd96; k_b = -12'sd40; k_c = 12'sd24;
      for (int i = 0; i < 6; i++) begin
         adc_data = 12'($urandom_range(1900, 2200));
         drive_tick(1, 6);
      end
      repeat (10) @(negedge clk);
      checks++; if (overrun !== 1'b0)     begin failures++; $display("FAIL b2b_overrun got %0b expected 0", overrun); end
      checks++; if (pulse_cnt - p0 !== 6) begin failures++; $display("FAIL b2b_pulses got %0d expected 6", pulse_cnt - p0); end
   endtask

   task automatic test_long_tick();
      int p0;
      p0 = pulse_cnt;
      vref = 12'd2048;
      for (int i = 0; i < 10; i++) begin
         k_a      = 12'($urandom_range(0, 512));
         k_b      = 12'(-int'($urandom_range(0, 256)));
         k_c      = 12'($urandom_range(0, 128));
         adc_data = 12'($urandom_range(1800, 2300));
         drive_tick(4, 128);
      end
      checks++; if (pulse_cnt - p0 !== 10) begin failures++; $display("FAIL long_pulses got %0d expected 10", pulse_cnt - p0); end
      checks++; if (overrun !== 1'b0)      begin failures++; $display("FAIL long_overrun got %0b expected 0", overrun); end
      checks++; if (sb.size() !== 0)       begin failures++; $display("FAIL long_timeout got %0d pending expected 0", sb.size()); end
   endtask

   initial begin
      rst = 1'b1; comp_tick = 1'b0;
      vref = '0; adc_data = '0; k_a = '0; k_b = '0; k_c = '0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_p_step();
      test_negative();
      test_overrun();
      apply_reset();
      test_deriv();
      apply_reset();
      test_back_to_back();
      apply_reset();
      test_long_tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got no finish expected finish before time limit");
      $fatal(1, "timeout");
   end

endmodule
